// File: rtl/excess3_to_bcd_serial_pkg.sv
// Shared constants for the serial Excess-3 <-> BCD digit link: state encodings,
// digit length and the Excess-3 offset.
package excess3_to_bcd_serial_pkg;

  localparam int unsigned ST_W       = 4;
  localparam int unsigned DIGIT_BITS = 4;
  localparam int unsigned OFFSET     = 3;

  // Bit position / borrow / h (d1|d2 seen so far) encoded per state
  typedef enum logic [ST_W-1:0] {
    S_A   = ST_W'(0),
    S_B0  = ST_W'(1),
    S_B1  = ST_W'(2),
    S_C0  = ST_W'(3),
    S_C1  = ST_W'(4),
    S_C1H = ST_W'(5),
    S_D0  = ST_W'(6),
    S_D0H = ST_W'(7),
    S_D1H = ST_W'(8)
  } state_t;

endpackage

// File: rtl/excess3_to_bcd_serial.sv
// Serial Excess-3 to BCD decoder: LSB-first, 4 bits per digit, Mealy outputs.
// Optional macro EX3_ERR_STICKY_EN adds a registered sticky invalid-code flag.
module excess3_to_bcd_serial
  import excess3_to_bcd_serial_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic x,
  output logic z,
  output logic last,
  output logic err
`ifdef EX3_ERR_STICKY_EN
  ,
  output logic err_sticky
`endif
);

  state_t state_q;
  state_t state_d;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit-serial subtraction of 0011 with borrow tracking; err on bit 3 when D >= 10
  always_comb begin
    state_d = S_A;
    z       = 1'b0;
    last    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_A: begin
        z       = ~x;
        state_d = x ? S_B0 : S_B1;
      end
      S_B0: begin
        z       = ~x;
        state_d = x ? S_C0 : S_C1H;
      end
      S_B1: begin
        z       = x;
        state_d = x ? S_C1H : S_C1;
      end
      S_C0: begin
        z       = x;
        state_d = x ? S_D0H : S_D0;
      end
      S_C1: begin
        z       = ~x;
        state_d = x ? S_D0 : S_D1H;
      end
      S_C1H: begin
        z       = ~x;
        state_d = x ? S_D0H : S_D1H;
      end
      S_D0: begin
        z    = x;
        last = 1'b1;
      end
      S_D0H: begin
        z    = x;
        err  = x;
        last = 1'b1;
      end
      S_D1H: begin
        z    = ~x;
        err  = ~x;
        last = 1'b1;
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

`ifdef EX3_ERR_STICKY_EN
  logic err_sticky_q;
  logic err_sticky_d;

  always_comb begin
    err_sticky_d = err_sticky_q | err;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// Self-checking bench for excess3_to_bcd_serial; build with EX3_ERR_STICKY_EN
// defined to also exercise the sticky error flag.
module tb_excess3_to_bcd_serial;

  typedef struct packed {
    logic z;
    logic last;
    logic err;
  } exp_t;

  logic clock;
  logic reset;
  logic x;
  logic z;
  logic last;
  logic err;
`ifdef EX3_ERR_STICKY_EN
  logic err_sticky;
`endif

  int   checks;
  int   errors;
  exp_t sb_q[$];

  excess3_to_bcd_serial dut (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .z     (z),
    .last  (last),
    .err   (err)
`ifdef EX3_ERR_STICKY_EN
    ,
    .err_sticky (err_sticky)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Called at a falling edge: drive one bit, push its expectation, pop and
  // compare just after, then advance to the next falling edge.
  task automatic send_bit(input logic xb, input exp_t e, input string name);
    exp_t got;
    exp_t want;
    x = xb;
    sb_q.push_back(e);
    #1;
    got  = '{z: z, last: last, err: err};
    want = sb_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: z/last/err got %b%b%b expected %b%b%b at %0t",
               name, got.z, got.last, got.err, want.z, want.last, want.err, $time);
    end
    @(negedge clock);
  endtask

  // Send nbits of Excess-3 code e; expected decoded value is (e - 3) mod 16.
  task automatic send_digit_n(input logic [3:0] e, input int nbits, input string name);
    logic [3:0] d;
    logic       bad;
    exp_t       ex;
    d   = 4'(e - 4'd3);
    bad = (e < 4'd3) || (e > 4'd12);
    for (int i = 0; i < nbits; i++) begin
      ex = '{z: d[i], last: (i == 3), err: (i == 3) && bad};
      send_bit(e[i], ex, name);
    end
  endtask

  task automatic send_digit(input logic [3:0] e, input string name);
    send_digit_n(e, 4, name);
  endtask

  // Assert reset at a falling edge, check outputs held, release at a later falling edge.
  task automatic do_reset(input logic xv, input string name);
    exp_t got;
    exp_t want;
    reset = 1'b0;
    x     = xv;
    #1;
    got  = '{z: z, last: last, err: err};
    want = '{z: ~xv, last: 1'b0, err: 1'b0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: z/last/err got %b%b%b expected %b%b%b",
               name, got.z, got.last, got.err, want.z, want.last, want.err);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1, "reset_x1");
    do_reset(1'b0, "reset_x0");
  endtask

  task automatic test_basic();
    send_digit(4'b0011, "e0011_d0");
    send_digit(4'b1100, "e1100_d9");
    send_digit(4'b0111, "e0111_d4");
  endtask

  task automatic test_invalid();
    send_digit(4'b0000, "e0000_d13");
    send_digit(4'b1101, "e1101_d10");
    send_digit(4'b0010, "e0010_d15");
    send_digit(4'b1111, "e1111_d12");
  endtask

  // Encoder output (BCD + 3) fed back must reproduce the BCD digit, never err
  task automatic test_loopback();
    logic [3:0] e;
    logic [3:0] bcd;
    exp_t       ex;
    for (int dgt = 0; dgt < 10; dgt++) begin
      bcd = 4'(dgt);
      e   = 4'(bcd + 4'd3);
      for (int i = 0; i < 4; i++) begin
        ex = '{z: bcd[i], last: (i == 3), err: 1'b0};
        send_bit(e[i], ex, "loopback");
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      send_digit(4'($urandom_range(0, 15)), "random_b2b");
    end
  endtask

  task automatic test_mid_reset();
    send_digit_n(4'b1010, 2, "partial_pre_reset");
    do_reset(1'b1, "reset_mid_digit");
    send_digit(4'b0101, "e0101_after_reset");
  endtask

`ifdef EX3_ERR_STICKY_EN
  task automatic chk_sticky(input logic want, input string name);
    checks++;
    if (err_sticky !== want) begin
      errors++;
      $display("FAIL %s: err_sticky got %b expected %b at %0t", name, err_sticky, want, $time);
    end
  endtask

  task automatic test_sticky();
    do_reset(1'b0, "reset_before_sticky");
    chk_sticky(1'b0, "sticky_after_reset");
    send_digit(4'b0110, "sticky_valid");
    chk_sticky(1'b0, "sticky_after_valid");
    send_digit_n(4'b1111, 3, "sticky_bad_head");
    chk_sticky(1'b0, "sticky_before_last_edge");
    send_bit(1'b1, '{z: 1'b1, last: 1'b1, err: 1'b1}, "sticky_bad_last");
    chk_sticky(1'b1, "sticky_set");
    send_digit(4'b1000, "sticky_later_valid");
    chk_sticky(1'b1, "sticky_holds");
    do_reset(1'b1, "reset_clear_sticky");
    chk_sticky(1'b0, "sticky_cleared");
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    x      = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_invalid();
    test_loopback();
    test_back_to_back();
    test_mid_reset();
`ifdef EX3_ERR_STICKY_EN
    test_sticky();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
